// File: rtl/stack_sequencer_pkg.sv
// stack_sequencer_pkg: interrupt type codes, sequencer states and default stack/vector constants
package stack_sequencer_pkg;
  typedef enum logic [1:0] {
    INT_BRK = 2'b00,
    INT_IRQ = 2'b01,
    INT_NMI = 2'b10,
    INT_RST = 2'b11
  } int_type_e;
  typedef enum logic [3:0] {
    IDLE,
    PUSH_PCH,
    PUSH_PCL,
    PUSH_P,
    VEC_LO,
    VEC_HI,
    PULL_P,
    PULL_PCL,
    PULL_PCH,
    FINISH
  } state_e;
  localparam logic [7:0]  DEF_STACK_PAGE = 8'h01;
  localparam logic [15:0] DEF_NMI_VEC    = 16'hFFFA;
  localparam logic [15:0] DEF_RST_VEC    = 16'hFFFC;
  localparam logic [15:0] DEF_IRQ_VEC    = 16'hFFFE;
endpackage

// File: rtl/stack_sequencer.sv
// stack_sequencer: interrupt-entry push/vector and RTI pull engine owning SP; NMI_HIJACK_EN lets NMI steal a BRK/IRQ vector
module stack_sequencer
  import stack_sequencer_pkg::*;
#(
  parameter logic [7:0]  STACK_PAGE = DEF_STACK_PAGE,
  parameter logic [15:0] NMI_VEC    = DEF_NMI_VEC,
  parameter logic [15:0] RST_VEC    = DEF_RST_VEC,
  parameter logic [15:0] IRQ_VEC    = DEF_IRQ_VEC
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        start_int,
  input  logic [1:0]  int_type,
  input  logic        start_rti,
  input  logic        nmi_req,
  input  logic [15:0] pc_in,
  input  logic [7:0]  p_in,
  input  logic        sp_wr,
  input  logic [7:0]  sp_wdata,
  input  logic [7:0]  mem_rdata,
  input  logic        mem_ready,
  output logic [15:0] mem_addr,
  output logic [7:0]  mem_wdata,
  output logic        mem_we,
  output logic        mem_re,
  output logic [7:0]  sp_out,
  output logic        p_load,
  output logic [7:0]  p_data,
  output logic        set_i,
  output logic [15:0] pc_out,
  output logic        pc_load,
  output logic        busy,
  output logic        done
);
  state_e      state, state_n;
  int_type_e   int_q;
  logic [15:0] pc_q, vec;
  logic [7:0]  sp, lo;
  logic        hijack, push, pull, bus, acc;
  logic        unused_bits;
  assign unused_bits = ^p_in[5:4];
  assign push = state inside {PUSH_PCH, PUSH_PCL, PUSH_P};
  assign pull = state inside {PULL_P, PULL_PCL, PULL_PCH};
  assign bus  = push || pull || state inside {VEC_LO, VEC_HI};
  assign acc  = bus && mem_ready;
`ifdef NMI_HIJACK_EN
  logic nmi_seen;
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) nmi_seen <= 1'b0;
    else if (state == IDLE) nmi_seen <= 1'b0;
    else if (push && nmi_req && int_q inside {INT_BRK, INT_IRQ}) nmi_seen <= 1'b1;
  end
  assign hijack = nmi_seen;
`else
  logic unused_nmi;
  assign unused_nmi = nmi_req;
  assign hijack = 1'b0;
`endif
  assign vec = (hijack || int_q == INT_NMI) ? NMI_VEC : int_q == INT_RST ? RST_VEC : IRQ_VEC;
  always_comb begin
    state_n = state;
    case (state)
      IDLE:     state_n = start_int ? PUSH_PCH : start_rti ? PULL_P : IDLE;
      PUSH_PCH: state_n = PUSH_PCL;
      PUSH_PCL: state_n = PUSH_P;
      PUSH_P:   state_n = VEC_LO;
      VEC_LO:   state_n = VEC_HI;
      VEC_HI:   state_n = FINISH;
      PULL_P:   state_n = PULL_PCL;
      PULL_PCL: state_n = PULL_PCH;
      PULL_PCH: state_n = FINISH;
      default:  state_n = IDLE;
    endcase
    if (bus && !mem_ready) state_n = state;
  end
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state  <= IDLE;
      sp     <= 8'h00;
      int_q  <= INT_BRK;
      pc_q   <= 16'h0000;
      lo     <= 8'h00;
      pc_out <= 16'h0000;
      p_data <= 8'h00;
      p_load <= 1'b0;
      set_i  <= 1'b0;
    end else begin
      state  <= state_n;
      p_load <= acc && state == PULL_P;
      set_i  <= acc && state == VEC_LO;
      if (state == IDLE && start_int) begin
        int_q <= int_type_e'(int_type);
        pc_q  <= pc_in;
      end
      if (state == IDLE && sp_wr) sp <= sp_wdata;
      else if (acc && push) sp <= sp - 8'd1;
      else if (acc && pull) sp <= sp + 8'd1;
      if (acc && state inside {VEC_LO, PULL_PCL}) lo <= mem_rdata;
      if (acc && state inside {VEC_HI, PULL_PCH}) pc_out <= {mem_rdata, lo};
      if (acc && state == PULL_P) p_data <= mem_rdata;
    end
  end
  assign mem_addr  = push ? {STACK_PAGE, sp} :
                     pull ? {STACK_PAGE, sp + 8'd1} :
                     state == VEC_LO ? vec :
                     state == VEC_HI ? vec + 16'd1 : 16'h0000;
  assign mem_wdata = state == PUSH_PCH ? pc_q[15:8] :
                     state == PUSH_PCL ? pc_q[7:0] :
                     state == PUSH_P ? {p_in[7:6], 1'b1, int_q == INT_BRK, p_in[3:0]} : 8'h00;
  assign mem_we  = push && int_q != INT_RST;
  assign mem_re  = pull || state inside {VEC_LO, VEC_HI};
  assign sp_out  = sp;
  assign busy    = state != IDLE;
  assign pc_load = state == FINISH;
  assign done    = state == FINISH;
endmodule

// File: tb/tb_stack_sequencer.sv
// tb_stack_sequencer: directed stimulus with an event scoreboard checked by a negedge monitor
module tb_stack_sequencer;
  logic        clk = 1'b0, reset_n = 1'b0;
  logic        start_int = 1'b0, start_rti = 1'b0, nmi_req = 1'b0, sp_wr = 1'b0, mem_ready = 1'b1;
  logic [1:0]  int_type = 2'b00;
  logic [15:0] pc_in = 16'h0000;
  logic [7:0]  p_in = 8'h00, sp_wdata = 8'h00, mem_rdata;
  logic [15:0] mem_addr, pc_out;
  logic [7:0]  mem_wdata, sp_out, p_data;
  logic        mem_we, mem_re, p_load, set_i, pc_load, busy, done;
  logic [7:0]  mem [0:65535];
  typedef struct {int k; logic [15:0] a; logic [7:0] d;} ev_t;
  ev_t q[$];
  int n_cmp = 0, n_fail = 0;
  localparam int EW = 0, ER = 1, EP = 2, ES = 3, ED = 4;
  stack_sequencer dut (
    .clk(clk), .reset_n(reset_n), .start_int(start_int), .int_type(int_type),
    .start_rti(start_rti), .nmi_req(nmi_req), .pc_in(pc_in), .p_in(p_in),
    .sp_wr(sp_wr), .sp_wdata(sp_wdata), .mem_rdata(mem_rdata), .mem_ready(mem_ready),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_we(mem_we), .mem_re(mem_re),
    .sp_out(sp_out), .p_load(p_load), .p_data(p_data), .set_i(set_i),
    .pc_out(pc_out), .pc_load(pc_load), .busy(busy), .done(done)
  );
  always #5 clk = ~clk;
  assign mem_rdata = mem[mem_addr];
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endtask
  task automatic ex(input int k, input logic [15:0] a, input logic [7:0] d);
    q.push_back('{k, a, d});
  endtask
  task automatic pop(input int k, input logic [15:0] a, input logic [7:0] d);
    ev_t e;
    if (q.size() == 0) begin
      n_cmp++;
      n_fail++;
      $display("FAIL unexpected_event: got kind %0d addr %0h data %0h, expected none", k, a, d);
    end else begin
      e = q.pop_front();
      chk("ev_kind", k, e.k);
      if (k inside {EW, ER, ED}) chk("ev_addr", a, e.a);
      if (k inside {EW, EP, ED}) chk("ev_data", d, e.d);
    end
  endtask
  always @(negedge clk) begin
    if (reset_n) begin
      if (set_i) pop(ES, 16'h0, 8'h0);
      if (p_load) pop(EP, 16'h0, p_data);
      if (mem_ready && mem_we) pop(EW, mem_addr, mem_wdata);
      if (mem_ready && mem_re) pop(ER, mem_addr, 8'h0);
      if (done) begin
        pop(ED, pc_out, sp_out);
        chk("pc_load_with_done", pc_load, 1);
      end
    end
  end
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic set_sp(input logic [7:0] v);
    sp_wr = 1'b1;
    sp_wdata = v;
    tick;
    sp_wr = 1'b0;
    chk("sp_wr_load", sp_out, v);
  endtask
  task automatic run_int(input logic [1:0] t, input logic [15:0] pc, input logic [7:0] p);
    start_int = 1'b1;
    int_type = t;
    pc_in = pc;
    p_in = p;
    tick;
    start_int = 1'b0;
  endtask
  task automatic run_rti;
    start_rti = 1'b1;
    tick;
    start_rti = 1'b0;
  endtask
  task automatic wait_done(input int n0, input int lat, input string nm);
    int n = n0;
    while (!done && n < 60) begin
      tick;
      n++;
    end
    chk(nm, n, lat);
    tick;
  endtask
  initial begin
    #200000;
    $display("FAIL global_timeout: got no finish, expected finish");
    $fatal(1);
  end
  initial begin
    logic [15:0] va, pcv;
    for (int i = 0; i < 65536; i++) mem[i] = 8'h00;
    mem[16'hFFFA] = 8'h00; mem[16'hFFFB] = 8'h90;
    mem[16'hFFFC] = 8'h34; mem[16'hFFFD] = 8'h12;
    mem[16'hFFFE] = 8'h00; mem[16'hFFFF] = 8'h80;
    tick;
    tick;
    chk("rst_mem_addr", mem_addr, 0);
    chk("rst_mem_wdata", mem_wdata, 0);
    chk("rst_strobes", {mem_we, mem_re, p_load, set_i, pc_load, busy, done}, 0);
    chk("rst_sp", sp_out, 0);
    chk("rst_p_data", p_data, 0);
    chk("rst_pc_out", pc_out, 0);
    reset_n = 1'b1;
    tick;
    set_sp(8'hFF);
    ex(EW, 16'h01FF, 8'h12); ex(EW, 16'h01FE, 8'h34); ex(EW, 16'h01FD, 8'hA3);
    ex(ER, 16'hFFFE, 0); ex(ES, 0, 0); ex(ER, 16'hFFFF, 0); ex(ED, 16'h8000, 8'hFC);
    run_int(2'b01, 16'h1234, 8'hA3);
    wait_done(1, 6, "irq_latency");
    ex(EW, 16'h01FC, 8'hAB); ex(EW, 16'h01FB, 8'hCD); ex(EW, 16'h01FA, 8'h30);
    ex(ER, 16'hFFFE, 0); ex(ES, 0, 0); ex(ER, 16'hFFFF, 0); ex(ED, 16'h8000, 8'hF9);
    run_int(2'b00, 16'hABCD, 8'h00);
    wait_done(1, 6, "brk_latency");
    set_sp(8'h00);
    ex(ER, 16'hFFFC, 0); ex(ES, 0, 0); ex(ER, 16'hFFFD, 0); ex(ED, 16'h1234, 8'hFD);
    run_int(2'b11, 16'h1111, 8'h00);
    wait_done(1, 6, "reset_latency");
    set_sp(8'hFC);
    mem[16'h01FD] = 8'hC5; mem[16'h01FE] = 8'h78; mem[16'h01FF] = 8'h56;
    ex(ER, 16'h01FD, 0); ex(EP, 0, 8'hC5); ex(ER, 16'h01FE, 0); ex(ER, 16'h01FF, 0);
    ex(ED, 16'h5678, 8'hFF);
    run_rti;
    wait_done(1, 4, "rti_latency");
    set_sp(8'h80);
    ex(EW, 16'h0180, 8'hBE); ex(EW, 16'h017F, 8'h42); ex(EW, 16'h017E, 8'hEF);
    ex(ER, 16'hFFFE, 0); ex(ES, 0, 0); ex(ER, 16'hFFFF, 0); ex(ED, 16'h8000, 8'h7D);
    run_int(2'b01, 16'hBE42, 8'hFF);
    tick;
    mem_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      chk("stall_addr", mem_addr, 16'h017F);
      chk("stall_we", mem_we, 1);
      chk("stall_sp", sp_out, 8'h7F);
      tick;
    end
    chk("stall_wdata", mem_wdata, 8'h42);
    mem_ready = 1'b1;
    wait_done(5, 9, "stall_latency");
    set_sp(8'hFE);
    mem[16'h01FF] = 8'h11; mem[16'h0100] = 8'h22; mem[16'h0101] = 8'h33;
    ex(ER, 16'h01FF, 0); ex(EP, 0, 8'h11); ex(ER, 16'h0100, 0); ex(ER, 16'h0101, 0);
    ex(ED, 16'h3322, 8'h01);
    run_rti;
    wait_done(1, 4, "wrap_latency");
`ifdef NMI_HIJACK_EN
    va = 16'hFFFA; pcv = 16'h9000;
`else
    va = 16'hFFFE; pcv = 16'h8000;
`endif
    set_sp(8'hFF);
    ex(EW, 16'h01FF, 8'h22); ex(EW, 16'h01FE, 8'h33); ex(EW, 16'h01FD, 8'h20);
    ex(ER, va, 0); ex(ES, 0, 0); ex(ER, va + 16'd1, 0); ex(ED, pcv, 8'hFC);
    run_int(2'b01, 16'h2233, 8'h00);
    tick;
    nmi_req = 1'b1;
    tick;
    nmi_req = 1'b0;
    wait_done(3, 6, "hijack_latency");
    set_sp(8'hFF);
    ex(EW, 16'h01FF, 8'h01); ex(EW, 16'h01FE, 8'h02); ex(EW, 16'h01FD, 8'hE3);
    ex(ER, 16'hFFFA, 0); ex(ES, 0, 0); ex(ER, 16'hFFFB, 0); ex(ED, 16'h9000, 8'hFC);
    start_rti = 1'b1;
    run_int(2'b10, 16'h0102, 8'hC3);
    start_rti = 1'b0;
    tick;
    start_rti = 1'b1;
    sp_wr = 1'b1;
    sp_wdata = 8'h55;
    tick;
    start_rti = 1'b0;
    sp_wr = 1'b0;
    wait_done(3, 6, "both_latency");
    chk("no_rti_after_int", busy, 0);
    tick;
    chk("busy_start_dropped", busy, 0);
    chk("sp_wr_ignored_busy", sp_out, 8'hFC);
    ex(EW, 16'h01FC, 8'h77); ex(EW, 16'h01FB, 8'h88);
    run_int(2'b01, 16'h7788, 8'h00);
    tick;
    tick;
    reset_n = 1'b0;
    #1;
    chk("abort_busy", busy, 0);
    chk("abort_sp", sp_out, 0);
    chk("abort_strobes", {mem_we, mem_re, set_i, p_load, pc_load, done}, 0);
    chk("abort_addr", mem_addr, 0);
    chk("abort_pc_out", pc_out, 0);
    tick;
    reset_n = 1'b1;
    tick;
    tick;
    chk("sb_empty", q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
